btn_led_status_ctrl: RTL and testbench

//  Parametrised successor to the board-level button/RGB-LED status logic.
//  - Synchronises and debounces NUM_BTN raw buttons; emits levels and press/release pulses.
//  - Runs a press-driven colour-mode FSM and a programmable heartbeat.
//  - Drives an active-low RGB LED with PWM brightness control.
//  - Sits between board pins and the top level; btn_level feeds downstream reset/control.

---
 rtl/btn_led_status_ctrl.sv | 155 +++++++++++++++
 tb/tb_btn_led_status_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_led_status_ctrl.sv
// Button synchroniser/debouncer with press/release pulses, colour-mode FSM,
// heartbeat generator and PWM-dimmed active-low RGB LED driver.

module btn_debounce_lane #(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rls
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sync_out;

    assign sync_out = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn};
            press <= 1'b0;
            rls   <= 1'b0;
            if (sync_out == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // mismatch held long enough: commit level and pulse on the same edge
                level <= sync_out;
                cnt   <= '0;
                press <= sync_out;
                rls   <= ~sync_out;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module btn_led_status_ctrl #(
    parameter int NUM_BTN         = 2,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HB_HALF         = 6000000,
    parameter int PWM_BITS        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn,
    input  logic [PWM_BITS-1:0] pwm_duty,
    output logic [NUM_BTN-1:0]  btn_level,
    output logic [NUM_BTN-1:0]  btn_press,
    output logic [NUM_BTN-1:0]  btn_release,
    output logic                heartbeat,
    output logic [1:0]          mode,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b
);
    localparam int HW = $clog2(HB_HALF);

    typedef enum logic [1:0] {
        M_HB    = 2'd0,
        M_RED   = 2'd1,
        M_BLUE  = 2'd2,
        M_GREEN = 2'd3
    } mode_t;

    mode_t               state, state_nxt;
    logic [HW-1:0]       hb_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic                led_r_nxt, led_g_nxt, led_b_nxt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        btn_debounce_lane #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rls   (btn_release[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (hb_cnt == HW'(HB_HALF - 1)) begin
                hb_cnt    <= '0;
                heartbeat <= ~heartbeat;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end
    end

    assign pwm_on = (pwm_cnt < pwm_duty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= M_HB;
            led_r <= 1'b1;
            led_g <= 1'b1;
            led_b <= 1'b1;
        end else begin
            state <= state_nxt;
            led_r <= led_r_nxt;
            led_g <= led_g_nxt;
            led_b <= led_b_nxt;
        end
    end

    // home beats advance when both presses land on the same edge
    always_comb begin
        state_nxt = state;
        led_r_nxt = 1'b1;
        led_g_nxt = 1'b1;
        led_b_nxt = 1'b1;
        if (btn_press[1]) begin
            state_nxt = M_HB;
        end else if (btn_press[0]) begin
            case (state)
                M_HB:    state_nxt = M_RED;
                M_RED:   state_nxt = M_BLUE;
                M_BLUE:  state_nxt = M_GREEN;
                default: state_nxt = M_HB;
            endcase
        end
        case (state)
            M_HB:    led_g_nxt = ~(heartbeat & pwm_on);
            M_RED:   led_r_nxt = ~pwm_on;
            M_BLUE:  led_b_nxt = ~pwm_on;
            default: led_g_nxt = ~pwm_on;
        endcase
    end

    assign mode = state;
endmodule

// File: tb/tb_btn_led_status_ctrl.sv
// Scoreboarded bench: per-edge reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.

module tb_btn_led_status_ctrl;
    localparam int NB = 2;
    localparam int SS = 3;
    localparam int DB = 4;
    localparam int HB = 8;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn = '0;
    logic [PB-1:0] pwm_duty = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          heartbeat;
    logic [1:0]    mode;
    logic          led_r, led_g, led_b;

    btn_led_status_ctrl #(
        .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .HB_HALF(HB), .PWM_BITS(PB)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .pwm_duty(pwm_duty),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .heartbeat(heartbeat), .mode(mode), .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic       hb;
        logic [1:0] mode;
        logic       r;
        logic       g;
        logic       b;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: raw samples are stored per edge since reset; a level flips once
    // the last DB synchronised samples (raw delayed SS edges) all disagree with it.
    bit         raw [NB][8192];
    int         lastchg [NB];
    int         n = 0;
    bit [NB-1:0] m_lvl, m_prs, m_rel;
    int         m_mode = 0;
    bit         m_hb, m_r = 1, m_g = 1, m_b = 1;

    task automatic model_edge();
        bit pon, hbb, ok, s;
        exp_t e;
        if (reset) begin
            n = 0; m_lvl = '0; m_prs = '0; m_rel = '0; m_mode = 0; m_hb = 0;
            m_r = 1; m_g = 1; m_b = 1;
            for (int b = 0; b < NB; b++) lastchg[b] = 0;
        end else begin
            pon = ((n % 16) < int'(pwm_duty));
            hbb = ((n / HB) % 2) == 1;
            m_r = 1; m_g = 1; m_b = 1;
            case (m_mode)
                0: m_g = !(hbb && pon);
                1: m_r = !pon;
                2: m_b = !pon;
                default: m_g = !pon;
            endcase
            if (m_prs[1]) m_mode = 0;
            else if (m_prs[0]) m_mode = (m_mode + 1) % 4;
            n++;
            for (int b = 0; b < NB; b++) begin
                raw[b][n] = btn[b];
                m_prs[b] = 0; m_rel[b] = 0;
                ok = (n - DB + 1) > lastchg[b];
                for (int j = n - DB + 1; j <= n; j++) begin
                    s = (j > SS) ? raw[b][j-SS] : 1'b0;
                    if (s == m_lvl[b]) ok = 0;
                end
                if (ok) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_prs[b] = m_lvl[b];
                    m_rel[b] = ~m_lvl[b];
                    lastchg[b] = n;
                end
            end
            m_hb = ((n / HB) % 2) == 1;
        end
        e.lvl = m_lvl; e.prs = m_prs; e.rel = m_rel; e.hb = m_hb;
        e.mode = 2'(m_mode); e.r = m_r; e.g = m_g; e.b = m_b;
        sbq.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("btn_level", btn_level, e.lvl);
            chk("btn_press", btn_press, e.prs);
            chk("btn_release", btn_release, e.rel);
            chk("heartbeat", heartbeat, e.hb);
            chk("mode", mode, e.mode);
            chk("leds_rgb", {led_r, led_g, led_b}, {e.r, e.g, e.b});
            chk("led_one_active", (int'(!led_r) + int'(!led_g) + int'(!led_b)) <= 1, 1);
        end
    end

    task automatic step(input int k = 1);
        repeat (k) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic press_btn(input logic [NB-1:0] v);
        btn = v;  step(12);
        btn = '0; step(12);
    endtask

    initial begin
        int lowcnt;
        int seq [4] = '{1, 2, 3, 0};
        step(3);
        reset = 1'b0;

        // duty 0: nothing ever lights
        pwm_duty = 4'd0;
        step(2);
        lowcnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (!led_r || !led_g || !led_b) lowcnt++;
        end
        chk("duty0_any_led_on", lowcnt, 0);

        // clean press of advance -> RED
        pwm_duty = 4'd5;
        step(1);
        press_btn(2'b01);
        chk("mode_after_first_press", mode, 1);

        // 3-cycle glitch is swallowed
        btn = 2'b01; step(3);
        btn = 2'b00; step(12);
        chk("glitch_level", btn_level[0], 0);
        chk("glitch_mode", mode, 1);

        // half duty in RED
        pwm_duty = 4'd8;
        step(2);
        lowcnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (!led_r) lowcnt++;
        end
        chk("red_duty8_low", lowcnt, 8);

        // home, then four advances wrapping back to HB
        press_btn(2'b10);
        chk("mode_after_home", mode, 0);
        for (int i = 0; i < 4; i++) begin
            press_btn(2'b01);
            chk("mode_advance_seq", mode, seq[i]);
        end

        // simultaneous press in BLUE: home wins
        press_btn(2'b01);
        press_btn(2'b01);
        chk("mode_before_both", mode, 2);
        press_btn(2'b11);
        chk("mode_after_both", mode, 0);

        // near-full duty in HB across several heartbeat phases
        pwm_duty = 4'd15;
        step(40);

        // reset mid-debounce: outputs clear without a clock edge
        btn = 2'b01;
        step(5);
        reset = 1'b1;
        #1;
        chk("rst_level", btn_level, 0);
        chk("rst_press", btn_press, 0);
        chk("rst_release", btn_release, 0);
        chk("rst_hb", heartbeat, 0);
        chk("rst_mode", mode, 0);
        chk("rst_leds", {led_r, led_g, led_b}, 7);
        step(2);
        reset = 1'b0;
        step(20);

        // randomized phase
        for (int it = 0; it < 500; it++) begin
            btn = NB'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) pwm_duty = PB'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 2));
                reset = 1'b0;
            end
            step($urandom_range(1, 10));
        end
        btn = '0;
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
